// File: rtl/axi_burst_slave.sv
// AXI4 burst responder: turns read/write bursts into single-word memory-port accesses (WRAP bursts need AXI_SLV_WRAP_EN).
// Latency: memory write one cycle after each W beat; AR to first R beat 2 cycles, then one read beat per 2 cycles.
// Backpressure: one burst in flight; AW/AR held off until B / last R handshake; B and R outputs hold while not ready.
module axi_burst_slave #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 16
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic [AXI_ADDR_WIDTH-1:0] i_awaddr,
    input  logic [7:0]                i_awlen,
    input  logic [2:0]                i_awsize,
    input  logic [1:0]                i_awburst,
    input  logic                      i_awvalid,
    output logic                      o_awready,
    input  logic [AXI_DATA_WIDTH-1:0] i_wdata,
    input  logic                      i_wlast,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    output logic [1:0]                o_bresp,
    output logic                      o_bvalid,
    input  logic                      i_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] i_araddr,
    input  logic [7:0]                i_arlen,
    input  logic [2:0]                i_arsize,
    input  logic [1:0]                i_arburst,
    input  logic                      i_arvalid,
    output logic                      o_arready,
    output logic [AXI_DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]                o_rresp,
    output logic                      o_rlast,
    output logic                      o_rvalid,
    input  logic                      i_rready,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr_mem,
    output logic [AXI_DATA_WIDTH-1:0] o_data_mem,
    output logic                      o_we_mem,
    input  logic [AXI_DATA_WIDTH-1:0] i_data_mem
);
    localparam int AW = AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RD_ERR} state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                    state, state_nxt;
    logic                      rdy_q;
    logic [AW-1:0]             addr_q, addr_step;
    logic [8:0]                beats_q;
    logic [1:0]                burst_q;
    logic                      err_q;
    logic                      rd_hold_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
`ifdef AXI_SLV_WRAP_EN
    logic [7:0]                len_q;
    logic [AW-1:0]             wrap_mask;
`endif

    logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic [2:0]    req_size;
    logic [1:0]    req_burst;
    logic          req_err;

    // Ready is registered so it reads 0 while in reset; AR yields to a simultaneous AW.
    assign o_awready = rdy_q;
    assign o_arready = rdy_q & ~i_awvalid;
    assign o_wready  = (state == WR_DATA);
    assign o_bresp   = (o_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign o_rvalid  = (state == RD_DATA) || (state == RD_ERR);
    assign o_rlast   = o_rvalid && (beats_q == 9'd1);
    assign o_rresp   = (state == RD_ERR) ? RESP_SLVERR : RESP_OKAY;
    // First R cycle passes memory data straight through; stalled cycles replay the captured copy.
    assign o_rdata   = (state == RD_DATA) ? (rd_hold_q ? rdata_q : i_data_mem) : '0;

    assign aw_hs = i_awvalid & o_awready;
    assign ar_hs = i_arvalid & o_arready;
    assign w_hs  = i_wvalid & o_wready;
    assign r_hs  = o_rvalid & i_rready;
    assign b_hs  = o_bvalid & i_bready;

    assign req_addr  = aw_hs ? i_awaddr  : i_araddr;
    assign req_len   = aw_hs ? i_awlen   : i_arlen;
    assign req_size  = aw_hs ? i_awsize  : i_arsize;
    assign req_burst = aw_hs ? i_awburst : i_arburst;

`ifdef AXI_SLV_WRAP_EN
    assign wrap_mask = {{(AW-10){1'b0}}, len_q, 2'b11};
`endif

    // Classify the incoming request: bad size, too long, reserved or unsupported burst type.
    always_comb begin
        req_err = (req_size != 3'b010) || ({24'd0, req_len} >= 32'(MAX_BURST_LEN)) || (req_burst == 2'b11);
`ifdef AXI_SLV_WRAP_EN
        if (req_burst == BURST_WRAP &&
            !((req_len == 8'd1 || req_len == 8'd3 || req_len == 8'd7 || req_len == 8'd15) &&
              req_addr[1:0] == 2'b00))
            req_err = 1'b1;
`else
        if (req_burst == BURST_WRAP)
            req_err = 1'b1;
`endif
    end

    // Address of the following beat for the latched burst type.
    always_comb begin
        addr_step = addr_q;
        if (burst_q == BURST_INCR)
            addr_step = addr_q + AW'(4);
`ifdef AXI_SLV_WRAP_EN
        else if (burst_q == BURST_WRAP)
            addr_step = (addr_q & ~wrap_mask) | ((addr_q + AW'(4)) & wrap_mask);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs)      state_nxt = WR_DATA;
                else if (ar_hs) state_nxt = req_err ? RD_ERR : RD_ADDR;
            end
            WR_DATA: if (w_hs && i_wlast) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = (beats_q == 9'd1) ? IDLE : RD_ADDR;
            RD_ERR:  if (r_hs && beats_q == 9'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst bookkeeping, memory port and response registers.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            rdy_q      <= 1'b0;
            addr_q     <= '0;
            beats_q    <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            rd_hold_q  <= 1'b0;
            rdata_q    <= '0;
            o_addr_mem <= '0;
            o_data_mem <= '0;
            o_we_mem   <= 1'b0;
            o_bvalid   <= 1'b0;
`ifdef AXI_SLV_WRAP_EN
            len_q      <= '0;
`endif
        end else begin
            rdy_q    <= (state_nxt == IDLE);
            o_we_mem <= 1'b0;
            o_bvalid <= (state == WR_RESP) && !b_hs;
            case (state)
                IDLE: begin
                    if (aw_hs || ar_hs) begin
                        addr_q    <= req_addr;
                        beats_q   <= {1'b0, req_len} + 9'd1;
                        burst_q   <= req_burst;
                        err_q     <= req_err;
                        rd_hold_q <= 1'b0;
`ifdef AXI_SLV_WRAP_EN
                        len_q     <= req_len;
`endif
                        if (ar_hs && !req_err)
                            o_addr_mem <= {req_addr[AW-1:2], 2'b00};
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (beats_q != 9'd0) begin
                            beats_q <= beats_q - 9'd1;
                            addr_q  <= addr_step;
                            if (!err_q) begin
                                o_addr_mem <= {addr_q[AW-1:2], 2'b00};
                                o_data_mem <= i_wdata;
                                o_we_mem   <= 1'b1;
                            end
                        end
                        // wlast late (beat past len) or early (beats still owed) poisons the response.
                        if (beats_q == 9'd0 || (i_wlast && beats_q != 9'd1))
                            err_q <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rd_hold_q <= 1'b0;
                        beats_q   <= beats_q - 9'd1;
                        if (beats_q != 9'd1) begin
                            addr_q     <= addr_step;
                            o_addr_mem <= {addr_step[AW-1:2], 2'b00};
                        end
                    end else begin
                        rd_hold_q <= 1'b1;
                        rdata_q   <= o_rdata;
                    end
                end
                RD_ERR: begin
                    if (r_hs) beats_q <= beats_q - 9'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_slave.sv
// Bench for axi_burst_slave: scoreboarded write/read bursts against a registered-read memory model.
// Latency: checks AR-to-first-R of 2 cycles and B one cycle after the final memory write.
// Backpressure: R stalls via toggled rready; R outputs must hold while stalled.
module tb_axi_burst_slave;
    logic        clk = 1'b0;
    logic        arstn;
    logic [63:0] i_awaddr, i_araddr;
    logic [7:0]  i_awlen, i_arlen;
    logic [2:0]  i_awsize, i_arsize;
    logic [1:0]  i_awburst, i_arburst;
    logic        i_awvalid, i_wvalid, i_wlast, i_bready, i_arvalid, i_rready;
    logic [31:0] i_wdata, i_data_mem;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid, o_we_mem;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata, o_data_mem;
    logic [63:0] o_addr_mem;

    axi_burst_slave #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32), .MAX_BURST_LEN(16)) dut (
        .clk(clk), .arstn(arstn),
        .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_addr_mem(o_addr_mem), .o_data_mem(o_data_mem), .o_we_mem(o_we_mem), .i_data_mem(i_data_mem)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int we_cnt = 0, rbeat_cnt = 0, ar_hs_cnt = 0;
    int last_we_cyc = 0, b_rise_cyc = 0, rv_first_cyc = 0;
    logic rv_arm = 1'b0, bvalid_q = 1'b0, stall_q = 1'b0;
    logic [34:0] stall_val = '0;
    logic [95:0] exp_wr[$];   // {addr, data}
    logic [34:0] exp_rd[$];   // {rlast, rresp, rdata}

    // Memory model: synchronous write, registered read.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (o_we_mem) mem[o_addr_mem[13:2]] <= o_data_mem;
        i_data_mem <= mem[o_addr_mem[13:2]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboards memory writes and R beats, tracks stalls and event timing.
    always @(negedge clk) begin
        if (o_we_mem) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (exp_wr.size() == 0) check_eq("wr_extra", 128'(exp_wr.size()), 128'(1));
            else check_eq("wr_beat", 128'({o_addr_mem, o_data_mem}), 128'(exp_wr.pop_front()));
        end
        if (o_rvalid && i_rready) begin
            rbeat_cnt++;
            if (exp_rd.size() == 0) check_eq("rd_extra", 128'(exp_rd.size()), 128'(1));
            else check_eq("rd_beat", 128'({o_rlast, o_rresp, o_rdata}), 128'(exp_rd.pop_front()));
        end
        if (arstn && stall_q && o_rvalid)
            check_eq("r_stable", 128'({o_rlast, o_rresp, o_rdata}), 128'(stall_val));
        stall_q   = arstn && o_rvalid && !i_rready;
        stall_val = {o_rlast, o_rresp, o_rdata};
        if (o_rvalid && rv_arm) begin
            rv_first_cyc = cyc;
            rv_arm = 1'b0;
        end
        if (o_bvalid && !bvalid_q) b_rise_cyc = cyc;
        bvalid_q = o_bvalid;
        if (i_arvalid && o_arready) ar_hs_cnt++;
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return o_awready;
            1:       return o_arready;
            2:       return o_wready;
            3:       return o_bvalid;
            default: return o_rvalid;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sig(which)) return;
        end
        check_eq({tag, "_timeout"}, 128'(sig(which)), 128'(1));
    endtask

    task automatic send_aw(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        @(posedge clk); #1;
        i_awaddr = a; i_awlen = len; i_awsize = size; i_awburst = burst; i_awvalid = 1'b1;
        wait_for(0, "aw");
        @(posedge clk); #1;
        i_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output int hs_cyc);
        @(posedge clk); #1;
        i_araddr = a; i_arlen = len; i_arsize = size; i_arburst = burst; i_arvalid = 1'b1;
        rv_arm = 1'b1;
        wait_for(1, "ar");
        hs_cyc = cyc;
        @(posedge clk); #1;
        i_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size, input int nbeats,
                            input int n_exp, input logic [31:0] dbase, input logic [1:0] exp_resp);
        for (int i = 0; i < n_exp; i++) exp_wr.push_back({a + 64'(4 * i), dbase + 32'(i)});
        send_aw(a, len, size, 2'b01);
        for (int i = 0; i < nbeats; i++) begin
            i_wdata = dbase + 32'(i); i_wlast = (i == nbeats - 1); i_wvalid = 1'b1;
            wait_for(2, "w");
            @(posedge clk); #1;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        wait_for(3, "b");
        check_eq("bresp", 128'(o_bresp), 128'(exp_resp));
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int target, input bit toggle);
        for (int k = 0; k < 400 && rbeat_cnt < target; k++) begin
            i_rready = toggle ? k[0] : 1'b1;
            @(posedge clk); #1;
        end
        i_rready = 1'b1;
        check_eq("r_beats", 128'(rbeat_cnt), 128'(target));
    endtask

    int w0, r0, ar0, hs, b_cyc, ar_cyc;

    initial begin
        arstn = 1'b0;
        i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
        i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
        i_wdata = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b1; i_rready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctl", 128'({o_awready, o_arready, o_wready, o_bvalid, o_bresp, o_rvalid, o_rlast, o_rresp, o_we_mem}), 128'(0));
        check_eq("rst_dat", 128'({o_addr_mem, o_data_mem, o_rdata}), 128'(0));
        @(posedge clk); #1 arstn = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("idle_awready", 128'(o_awready), 128'(1));

        // 16-beat INCR write of 0..15 at 0x1000
        w0 = we_cnt;
        do_write(64'h1000, 8'd15, 3'b010, 16, 16, 32'd0, 2'b00);
        check_eq("wr16_count", 128'(we_cnt - w0), 128'(16));
        check_eq("b_after_we", 128'(b_rise_cyc - last_we_cyc), 128'(1));

        // 16-beat INCR read back with rready toggling
        for (int i = 0; i < 16; i++) exp_rd.push_back({i == 15, 2'b00, 32'(i)});
        r0 = rbeat_cnt;
        send_ar(64'h1000, 8'd15, 3'b010, 2'b01, hs);
        wait_beats(r0 + 16, 1'b1);
        check_eq("ar_to_rvalid", 128'(rv_first_cyc - hs), 128'(2));

        // AW and AR in the same cycle: write first, AR only after B
        exp_wr.push_back({64'h3000, 32'h55});
        exp_rd.push_back({1'b1, 2'b00, 32'd0});
        ar0 = ar_hs_cnt; r0 = rbeat_cnt;
        @(posedge clk); #1;
        i_awaddr = 64'h3000; i_awlen = 8'd0; i_awsize = 3'b010; i_awburst = 2'b01; i_awvalid = 1'b1;
        i_araddr = 64'h1000; i_arlen = 8'd0; i_arsize = 3'b010; i_arburst = 2'b01; i_arvalid = 1'b1;
        wait_for(0, "aw_both");
        check_eq("ar_blocked", 128'(o_arready), 128'(0));
        @(posedge clk); #1 i_awvalid = 1'b0;
        i_wdata = 32'h55; i_wlast = 1'b1; i_wvalid = 1'b1;
        wait_for(2, "w_both");
        @(posedge clk); #1 i_wvalid = 1'b0; i_wlast = 1'b0;
        wait_for(3, "b_both");
        b_cyc = cyc;
        check_eq("ar_held", 128'(ar_hs_cnt), 128'(ar0));
        check_eq("bresp_both", 128'(o_bresp), 128'(2'b00));
        wait_for(1, "ar_both");
        ar_cyc = cyc;
        check_eq("ar_after_b", 128'(ar_cyc > b_cyc), 128'(1));
        @(posedge clk); #1 i_arvalid = 1'b0;
        wait_beats(r0 + 1, 1'b0);

        // Early wlast: awlen=3 but wlast on beat 2
        w0 = we_cnt;
        do_write(64'h4000, 8'd3, 3'b010, 2, 2, 32'h40, 2'b10);
        check_eq("early_wlast_writes", 128'(we_cnt - w0), 128'(2));

        // Unsupported beat size: no memory writes
        w0 = we_cnt;
        do_write(64'h5000, 8'd3, 3'b011, 4, 0, 32'h50, 2'b10);
        check_eq("bad_size_writes", 128'(we_cnt - w0), 128'(0));

        // WRAP read of 4 beats starting mid-window
        do_write(64'h2000, 8'd3, 3'b010, 4, 4, 32'hA0, 2'b00);
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_SLV_WRAP_EN
            exp_rd.push_back({i == 3, 2'b00, 32'hA0 + 32'((i + 2) % 4)});
`else
            exp_rd.push_back({i == 3, 2'b10, 32'd0});
`endif
        end
        r0 = rbeat_cnt;
        send_ar(64'h2008, 8'd3, 3'b010, 2'b10, hs);
        wait_beats(r0 + 4, 1'b0);
        check_eq("wrap_no_writes", 128'(we_cnt - w0), 128'(0));

        // Reset during beat 5 of a 16-beat read
        for (int i = 0; i < 16; i++) exp_rd.push_back({i == 15, 2'b00, 32'(i)});
        r0 = rbeat_cnt;
        send_ar(64'h1000, 8'd15, 3'b010, 2'b01, hs);
        for (int k = 0; k < 200 && rbeat_cnt < r0 + 4; k++) begin
            @(posedge clk); #1;
        end
        check_eq("rst_wait", 128'(rbeat_cnt), 128'(r0 + 4));
        w0 = we_cnt;
        arstn = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("rst2_ctl", 128'({o_awready, o_arready, o_wready, o_bvalid, o_bresp, o_rvalid, o_rlast, o_rresp, o_we_mem}), 128'(0));
        check_eq("rst2_dat", 128'({o_addr_mem, o_data_mem, o_rdata}), 128'(0));
        exp_rd.delete();
        @(posedge clk); #1 arstn = 1'b1;
        for (int i = 0; i < 4; i++) exp_rd.push_back({i == 3, 2'b00, 32'(i)});
        r0 = rbeat_cnt;
        send_ar(64'h1000, 8'd3, 3'b010, 2'b01, hs);
        wait_beats(r0 + 4, 1'b0);
        check_eq("rst_no_writes", 128'(we_cnt - w0), 128'(0));

        repeat (3) @(posedge clk);
        check_eq("wr_queue_empty", 128'(exp_wr.size()), 128'(0));
        check_eq("rd_queue_empty", 128'(exp_rd.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_burst_slave.md
Name: axi_burst_slave

Overview:
- AXI4 responder (slave) end of the burst interface: accepts read/write bursts from the cache-side AXI master and turns each beat into single-word accesses on the simulated-memory port (o_addr_mem / o_data_mem / o_we_mem / i_data_mem).
- Sits between the AXI master and the memory model in the test environment.
- Cache lines of 512 bits move as 16 beats of 32 bits.

Parameters:
- AXI_ADDR_WIDTH, 64, address width on AXI and memory port
- AXI_DATA_WIDTH, 32, beat / memory word width
- MAX_BURST_LEN, 16, largest accepted beat count (AxLEN+1)

Ports:
- clk  in  1  clock
- arstn  in  1  synchronous active-low reset, sampled on rising clk
- i_awaddr  in  AXI_ADDR_WIDTH  write burst start address
- i_awlen  in  8  beats minus one
- i_awsize  in  3  beat size code
- i_awburst  in  2  burst type
- i_awvalid  in  1  AW valid
- o_awready  out  1  AW ready
- i_wdata  in  AXI_DATA_WIDTH  write beat data
- i_wlast  in  1  final write beat
- i_wvalid  in  1  W valid
- o_wready  out  1  W ready
- o_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- o_bvalid  out  1  B valid
- i_bready  in  1  B ready
- i_araddr  in  AXI_ADDR_WIDTH  read burst start address
- i_arlen  in  8  beats minus one
- i_arsize  in  3  beat size code
- i_arburst  in  2  burst type
- i_arvalid  in  1  AR valid
- o_arready  out  1  AR ready
- o_rdata  out  AXI_DATA_WIDTH  read beat data
- o_rresp  out  2  read response
- o_rlast  out  1  final read beat
- o_rvalid  out  1  R valid
- i_rready  in  1  R ready
- o_addr_mem  out  AXI_ADDR_WIDTH  memory word address, bits [1:0] forced to 0
- o_data_mem  out  AXI_DATA_WIDTH  memory write data
- o_we_mem  out  1  memory write strobe
- i_data_mem  in  AXI_DATA_WIDTH  memory read data, valid one cycle after o_addr_mem

Behaviour:
- Reset: all outputs 0; FSM to IDLE.
  - Reset mid-burst abandons the burst: no B/R response, no further memory writes.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RD_ERR.
- IDLE: o_awready = o_arready = 1 only when no request is pending.
  - If AWVALID and ARVALID are both high in one cycle, write wins (dirty eviction precedes refill); AR stays unaccepted.
  - A handshake latches address, beat count, burst and error flag.
  - Error flag is set when size != 3'b010, len+1 > MAX_BURST_LEN, or burst = 2'b11.
- Address step: +4 per beat for INCR (01); unchanged for FIXED (00); WRAP per the optional feature below.
- WR_DATA: o_wready = 1.
  - Each W handshake registers o_addr_mem / o_data_mem and pulses o_we_mem for exactly one cycle on the next cycle, then steps the address.
  - No write occurs if the error flag is set or the beat count is already exhausted.
  - Burst ends on the beat with i_wlast = 1, then goes to WR_RESP.
  - i_wlast early or late vs AWLEN sets SLVERR; writes beyond len are dropped.
- WR_RESP: o_bvalid = 1 with o_bresp (SLVERR if error, else OKAY); held until i_bready, then IDLE.
- RD_ADDR: drives o_addr_mem for one cycle, then RD_DATA.
- RD_DATA: captures i_data_mem into o_rdata; o_rvalid = 1; o_rlast = 1 on the final beat.
  - rdata, rlast and rresp stay stable while i_rready = 0.
  - On handshake: IDLE if last, else step address and return to RD_ADDR.
- Read timing: AR handshake at cycle N -> o_addr_mem at N+1 -> o_rvalid at N+2. Steady state is one beat per 2 cycles.
- Erroneous read goes to RD_ERR: returns len+1 beats of rdata = 0, rresp = 10, correct rlast, no memory access.
- o_we_mem is never high in any read state.

Optional Feature:
- Macro AXI_SLV_WRAP_EN.
  - Defined: burst = 2'b10 (WRAP) is accepted when len+1 is in {2,4,8,16} and the start address is 4-byte aligned. The address wraps inside an aligned window of (len+1)*4 bytes.
  - Not defined: WRAP is treated as an error burst and gets SLVERR (write: no memory writes; read: zero data).

Test Plan:
- 16-beat INCR write at 0x1000, data 0..15, bready = 1 -> 16 o_we_mem pulses at 0x1000..0x103C; bresp = 00 one cycle after the wlast beat is written.
- 16-beat INCR read at 0x1000 after the write, rready toggled 1/0 -> rdata 0..15 in order, stable while stalled; rlast only on beat 16; AR-to-first-rvalid = 2 cycles.
- AWVALID and ARVALID asserted in the same cycle -> AW accepted first; AR accepted only after B handshake completes.
- Write with awlen = 3 but wlast on beat 2 -> 2 memory writes, bresp = 10; awsize = 3'b011 -> 0 writes, bresp = 10.
- WRAP read, len = 3, addr 0x2008: with AXI_SLV_WRAP_EN -> addresses 0x2008, 0x200C, 0x2000, 0x2004; without it -> 4 beats of rresp = 10, rdata = 0.
- arstn low during beat 5 of a read -> outputs 0 next cycle; the next burst after reset completes normally.
